// File: rtl/ace_ccu_snoop_arbiter_if.sv
// Snoop arbiter bundle: requester side, conflict-manager check, held output and credit return.
// master : arbiter side (drives grants, cm candidate, held entry, credit state)
// slave  : environment side (requesters, conflict manager, interconnect, response tracker)
interface ace_ccu_snoop_arbiter_if #(
  parameter int unsigned NumInp         = 4,
  parameter int unsigned AcWidth        = 72,
  parameter int unsigned MaskWidth      = 4,
  parameter int unsigned CmAddrWidth    = 8,
  parameter int unsigned MaxOutstanding = 4
);
  localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic                                   en_i;
  logic [NumInp-1:0]                      inp_valid_i;
  logic [NumInp-1:0]                      inp_ready_o;
  logic [NumInp-1:0][AcWidth-1:0]         inp_ac_i;
  logic [NumInp-1:0][MaskWidth-1:0]       inp_mask_i;
  logic [NumInp-1:0][CmAddrWidth-1:0]     inp_idx_i;
  logic                                   cm_valid_o;
  logic [CmAddrWidth-1:0]                 cm_idx_o;
  logic                                   cm_stall_i;
  logic                                   oup_valid_o;
  logic                                   oup_ready_i;
  logic [AcWidth-1:0]                     oup_ac_o;
  logic [MaskWidth-1:0]                   oup_mask_o;
  logic [IdxW-1:0]                        oup_sel_o;
  logic                                   resp_done_i;
  logic [CntW-1:0]                        inflight_o;
  logic                                   idle_o;

  modport master (
    input  en_i, inp_valid_i, inp_ac_i, inp_mask_i, inp_idx_i,
           cm_stall_i, oup_ready_i, resp_done_i,
    output inp_ready_o, cm_valid_o, cm_idx_o, oup_valid_o, oup_ac_o,
           oup_mask_o, oup_sel_o, inflight_o, idle_o
  );

  modport slave (
    output en_i, inp_valid_i, inp_ac_i, inp_mask_i, inp_idx_i,
           cm_stall_i, oup_ready_i, resp_done_i,
    input  inp_ready_o, cm_valid_o, cm_idx_o, oup_valid_o, oup_ac_o,
           oup_mask_o, oup_sel_o, inflight_o, idle_o
  );
endinterface

// File: rtl/ace_ccu_snoop_arbiter.sv
// Round-robin arbiter for the single CCU snoop-issue slot.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_i  : synchronous active-high reset
//   bus    : arbiter bundle (master modport) - requester valid/ready/payload,
//            conflict-manager candidate + stall, registered AC/mask/sel output,
//            credit return (resp_done_i) and in-flight count / idle.
module ace_ccu_snoop_arbiter #(
  parameter int unsigned NumInp         = 4,
  parameter int unsigned AcWidth        = 72,
  parameter int unsigned MaskWidth      = 4,
  parameter int unsigned CmAddrWidth    = 8,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  ace_ccu_snoop_arbiter_if.master     bus
);
  localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0]      prio_q;
  logic [CntW-1:0]      inflight_q;
  logic                 valid_q;
  logic [AcWidth-1:0]   ac_q;
  logic [MaskWidth-1:0] mask_q;
  logic [IdxW-1:0]      sel_q;

  logic                 found;
  logic [IdxW-1:0]      win;
  logic                 reg_free;
  logic                 credit_ok;
  logic                 grant;
  logic [NumInp-1:0]    ready;

  // First valid requester at or above the priority pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      if (!found && bus.inp_valid_i[(32'(prio_q) + k) % NumInp]) begin
        found = 1'b1;
        win   = IdxW'((32'(prio_q) + k) % NumInp);
      end
    end
  end

  // A completion in the same cycle frees the credit the new grant needs.
  assign credit_ok = (inflight_q < CntW'(MaxOutstanding)) ||
                     ((inflight_q == CntW'(MaxOutstanding)) && bus.resp_done_i);
  assign reg_free  = !valid_q || bus.oup_ready_i;
  assign grant     = found && bus.en_i && !bus.cm_stall_i && reg_free &&
                     credit_ok && !rst_i;

  // One-hot accept toward the winning requester only.
  always_comb begin
    ready = '0;
    if (grant) ready[win] = 1'b1;
  end

  assign bus.inp_ready_o = ready;
  assign bus.cm_valid_o  = (|bus.inp_valid_i) && bus.en_i;
  assign bus.cm_idx_o    = found ? bus.inp_idx_i[win] : '0;
  assign bus.oup_valid_o = valid_q;
  assign bus.oup_ac_o    = ac_q;
  assign bus.oup_mask_o  = mask_q;
  assign bus.oup_sel_o   = sel_q;
  assign bus.inflight_o  = inflight_q;
  assign bus.idle_o      = (inflight_q == '0);

  // Held output entry, priority pointer and credit counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      ac_q       <= '0;
      mask_q     <= '0;
      sel_q      <= '0;
      prio_q     <= '0;
      inflight_q <= '0;
    end else begin
      if (grant) begin
        valid_q <= 1'b1;
        ac_q    <= bus.inp_ac_i[win];
        mask_q  <= bus.inp_mask_i[win];
        sel_q   <= win;
        prio_q  <= (win == IdxW'(NumInp - 1)) ? '0 : win + IdxW'(1);
      end else if (bus.oup_ready_i) begin
        valid_q <= 1'b0;
      end

      if (grant && !bus.resp_done_i) begin
        inflight_q <= inflight_q + CntW'(1);
      end else if (!grant && bus.resp_done_i && (inflight_q != '0)) begin
        inflight_q <= inflight_q - CntW'(1);
      end
    end
  end

  // A completion can only return a credit that was handed out.
  resp_done_has_credit_a : assert property (
    @(posedge clk_i) disable iff (rst_i) bus.resp_done_i |-> (inflight_q != '0)
  );
endmodule

// File: tb/tb_ace_ccu_snoop_arbiter.sv
module tb_ace_ccu_snoop_arbiter;
  localparam int unsigned N    = 4;
  localparam int unsigned ACW  = 72;
  localparam int unsigned MW   = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ace_ccu_snoop_arbiter_if #(
    .NumInp(N), .AcWidth(ACW), .MaskWidth(MW), .CmAddrWidth(CW), .MaxOutstanding(MAXO)
  ) bus ();

  ace_ccu_snoop_arbiter #(
    .NumInp(N), .AcWidth(ACW), .MaskWidth(MW), .CmAddrWidth(CW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_dut_grants = 0;

  // Requester-side pending requests (held stable until accepted).
  bit              pend  [N];
  logic [ACW-1:0]  pac   [N];
  logic [MW-1:0]   pmask [N];
  logic [CW-1:0]   pidx  [N];

  // Reference model of the arbiter's visible state.
  bit             m_valid;
  logic [ACW-1:0] m_ac;
  logic [MW-1:0]  m_mask;
  int             m_sel;
  int             m_prio;
  int             m_infl;

  // Stimulus knobs.
  bit s_en, s_stall, s_rdy, s_done, s_rst;
  int req_pct;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    pend[i]  = 1'b1;
    pac[i]   = ACW'({$urandom(), $urandom(), $urandom()});
    pmask[i] = MW'($urandom());
    pidx[i]  = CW'($urandom_range(15));
  endtask

  // One cycle: entered at negedge, drives, checks, advances the model, returns at next negedge.
  task automatic step();
    int w;
    int j;
    bit cand_v;
    bit credit;
    bit g;
    logic [N-1:0] exp_rdy;

    for (int i = 0; i < N; i++)
      if (!pend[i] && ($urandom_range(99) < req_pct)) new_req(i);
    for (int i = 0; i < N; i++) begin
      bus.inp_valid_i[i] = pend[i];
      bus.inp_ac_i[i]    = pac[i];
      bus.inp_mask_i[i]  = pmask[i];
      bus.inp_idx_i[i]   = pidx[i];
    end
    bus.en_i        = s_en;
    bus.cm_stall_i  = s_stall;
    bus.oup_ready_i = s_rdy;
    bus.resp_done_i = s_done;
    rst             = s_rst;
    #1;

    w = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_prio + k) % N;
      if (w < 0 && pend[j]) w = j;
    end
    cand_v  = (w >= 0) && s_en;
    credit  = (m_infl < MAXO) || (m_infl == MAXO && s_done);
    g       = cand_v && !s_stall && (!m_valid || s_rdy) && credit && !s_rst;
    exp_rdy = '0;
    if (g) exp_rdy[w] = 1'b1;

    check("inp_ready", 128'(bus.inp_ready_o), 128'(exp_rdy));
    check("cm_valid", 128'(bus.cm_valid_o), 128'(cand_v));
    if (w >= 0) check("cm_idx", 128'(bus.cm_idx_o), 128'(pidx[w]));
    else        check("cm_idx_none", 128'(bus.cm_idx_o), 128'(0));
    if (|bus.inp_ready_o) n_dut_grants++;

    check("oup_valid", 128'(bus.oup_valid_o), 128'(m_valid));
    check("oup_ac", 128'(bus.oup_ac_o), 128'(m_ac));
    check("oup_mask", 128'(bus.oup_mask_o), 128'(m_mask));
    check("oup_sel", 128'(bus.oup_sel_o), 128'(m_sel));
    check("inflight", 128'(bus.inflight_o), 128'(m_infl));
    check("idle", 128'(bus.idle_o), 128'(m_infl == 0));

    if (s_rst) begin
      m_valid = 1'b0; m_ac = '0; m_mask = '0; m_sel = 0; m_prio = 0; m_infl = 0;
    end else begin
      if (g) begin
        m_valid = 1'b1;
        m_ac    = pac[w];
        m_mask  = pmask[w];
        m_sel   = w;
        m_prio  = (w + 1) % N;
        pend[w] = 1'b0;
        m_infl++;
      end else if (s_rdy) begin
        m_valid = 1'b0;
      end
      if (s_done && m_infl > 0) m_infl--;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit clear_reqs);
    if (clear_reqs) for (int i = 0; i < N; i++) pend[i] = 1'b0;
    s_rst = 1'b1; s_done = 1'b0; req_pct = 0;
    step();
    s_rst = 1'b0;
  endtask

  int g0;

  initial begin
    m_valid = 1'b0; m_ac = '0; m_mask = '0; m_sel = 0; m_prio = 0; m_infl = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pac[i] = '0; pmask[i] = '0; pidx[i] = '0;
    end
    s_en = 1'b1; s_stall = 1'b0; s_rdy = 1'b1; s_done = 1'b0; s_rst = 1'b1; req_pct = 0;
    bus.inp_valid_i = '0; bus.inp_ac_i = '0; bus.inp_mask_i = '0; bus.inp_idx_i = '0;
    bus.en_i = 1'b0; bus.cm_stall_i = 1'b0; bus.oup_ready_i = 1'b0; bus.resp_done_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_rst = 1'b0;

    // Round robin with all requesters valid and credits returned each cycle.
    req_pct = 100; s_rdy = 1'b1; s_en = 1'b1; s_stall = 1'b0;
    for (int c = 0; c < 7; c++) begin
      s_done = (m_infl > 0);
      step();
    end

    // Credit exhaustion, then a completion lets a grant through in the same cycle.
    do_reset(1'b1);
    req_pct = 100; s_done = 1'b0;
    g0 = n_dut_grants;
    repeat (7) step();
    check("credit_grants", 128'(n_dut_grants - g0), 128'(MAXO));
    check("credit_full", 128'(bus.inflight_o), 128'(MAXO));
    s_done = 1'b1;
    step();
    s_done = 1'b0;
    check("credit_regrant", 128'(n_dut_grants - g0), 128'(MAXO + 1));
    check("credit_still_full", 128'(bus.inflight_o), 128'(MAXO));

    // Stalled candidate is re-presented without skipping to a lower-priority requester.
    do_reset(1'b1);
    req_pct = 0;
    new_req(2); new_req(3);
    s_stall = 1'b1;
    g0 = n_dut_grants;
    repeat (5) step();
    check("stall_no_grant", 128'(n_dut_grants - g0), 128'(0));
    s_stall = 1'b0;
    repeat (3) step();
    check("stall_released", 128'(n_dut_grants - g0), 128'(2));

    // Output back-pressure holds the entry and blocks further grants.
    do_reset(1'b1);
    new_req(0); new_req(1);
    s_rdy = 1'b1; step();
    s_rdy = 1'b0; repeat (3) step();
    s_rdy = 1'b1; repeat (2) step();

    // Reset mid-transfer discards the held entry and all credits.
    do_reset(1'b1);
    req_pct = 100; s_rdy = 1'b1; s_done = 1'b0;
    repeat (3) step();
    check("pre_reset_inflight", 128'(bus.inflight_o), 128'(3));
    do_reset(1'b0);
    req_pct = 0;
    step();

    // Disable: held entry drains, no accepts; re-enable resumes from the pointer.
    do_reset(1'b1);
    req_pct = 100;
    s_rdy = 1'b0; step();
    s_en = 1'b0; s_rdy = 1'b1;
    g0 = n_dut_grants;
    repeat (4) begin s_done = (m_infl > 0); step(); end
    check("disabled_no_grant", 128'(n_dut_grants - g0), 128'(0));
    s_en = 1'b1; s_done = 1'b0;
    repeat (3) step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      s_rst   = ($urandom_range(99) < 1);
      s_en    = ($urandom_range(99) < 90);
      s_stall = ($urandom_range(99) < 25);
      s_rdy   = ($urandom_range(99) < 70);
      s_done  = (m_infl > 0) && ($urandom_range(99) < 40);
      req_pct = 40;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ace_ccu_snoop_arbiter.md
# ace_ccu_snoop_arbiter

Round-robin arbiter that shares the CCU snoop interconnect's single snoop-issue slot between `NumInp` snoop requesters (read/write paths of each group). Each request carries its conflict-manager line index, and the candidate is checked against the conflict manager before any grant. Outstanding snoops are bounded by a credit counter that completed snoop responses return. The arbiter sits between the master-path snoop request outputs and the snoop interconnect input stage, and presents a registered AC+mask output.

## Interface
- `NumInp`, 4: number of requesters (≥2).
- `AcWidth`, 72: width of the opaque AC payload (address + snoop + prot).
- `MaskWidth`, 4: width of the target-port domain mask.
- `CmAddrWidth`, 8: conflict-manager line index width.
- `MaxOutstanding`, 4: maximum in-flight snoops (≥1), held entry included.
- Derived: `IdxW = $clog2(NumInp)`, `CntW = $clog2(MaxOutstanding+1)`.

- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: when low, no new grants; held entry and credits still drain.
- `inp_valid_i` in NumInp: request valid per requester.
- `inp_ready_o` out NumInp: one-hot grant (accept) per requester.
- `inp_ac_i` in NumInp×AcWidth: AC payload per requester.
- `inp_mask_i` in NumInp×MaskWidth: target mask per requester.
- `inp_idx_i` in NumInp×CmAddrWidth: conflict line index per requester.
- `cm_valid_o` out 1: candidate present for conflict check.
- `cm_idx_o` out CmAddrWidth: candidate line index.
- `cm_stall_i` in 1: conflict manager blocks the current candidate.
- `oup_valid_o` out 1: registered output valid.
- `oup_ready_i` in 1: interconnect accepts output.
- `oup_ac_o` out AcWidth, `oup_mask_o` out MaskWidth, `oup_sel_o` out IdxW: payload, mask and source of the held entry.
- `resp_done_i` in 1: one snoop fully completed (CR/CD done); returns one credit.
- `inflight_o` out CntW: current in-flight count.
- `idle_o` out 1: `inflight_o == 0`.

## Operation
- Output register holds one entry; `load = grant`; register is free when `!oup_valid_o || oup_ready_i`.
- Candidate: first valid requester searching upward (wrapping) from priority pointer `prio_q`. `cm_valid_o` = any valid && `en_i`; `cm_idx_o` = candidate's `inp_idx_i` (0 when no candidate).
- Grant when all hold: candidate exists, `en_i`, `!cm_stall_i`, register free, and `inflight_q < MaxOutstanding` or (`inflight_q == MaxOutstanding` and `resp_done_i`).
- On grant: `inp_ready_o[w]=1` (one-hot, only winner w), register loads payload/mask/`sel=w`, `oup_valid_o` next cycle = 1, `prio_q <= (w+1) mod NumInp`.
- Stall: no grant, `prio_q` unchanged, and the same candidate is re-presented (no skipping to lower-priority requesters); this preserves per-index ordering.
- Held entry: `oup_valid_o` stays high and payload stable until `oup_ready_i`; on handshake without new grant, `oup_valid_o <= 0`.
- Credit counter `inflight_q`: +1 on grant, −1 on `resp_done_i`; both in the same cycle → unchanged. `resp_done_i` at 0 is illegal (assertion); counter saturates at 0.
- `en_i` deassert: current held entry still completes; no new `inp_ready_o`.
- Reset: `oup_valid_o=0`, `oup_ac_o/oup_mask_o/oup_sel_o=0`, `prio_q=0`, `inflight_q=0`, `idle_o=1`, `inp_ready_o=0`, `cm_valid_o=0` unless inputs valid after reset release. Reset mid-transfer discards the held entry and all credits.

## Timing
- `inp_ready_o`, `cm_valid_o`, `cm_idx_o` combinational from inputs and state; `cm_stall_i` → `inp_ready_o` combinational path.
- Grant in cycle N → `oup_valid_o` high in N+1.
- Back-to-back: with `oup_ready_i` held high and credits available, one grant per cycle.
- Requester must keep `inp_valid_i` and payload stable until `inp_ready_o`.
- `inflight_o` updates in cycle after grant/`resp_done_i`.

## Test plan
- Reset then all four requesters valid, no stall, ready=1, credits free → grants 0,1,2,3,0 on consecutive cycles; `oup_sel_o` = 0,1,2,3 one cycle later.
- MaxOutstanding=4, never return `resp_done_i` → exactly 4 grants, then `inp_ready_o=0`, `inflight_o=4`; one `resp_done_i` pulse → grant in that same cycle, `inflight_o` stays 4.
- Requester 2 alone with `cm_stall_i=1` for 5 cycles, requester 3 also valid → no grant either for 5 cycles, `cm_idx_o` = idx of 2; stall drops → 2 granted, then 3.
- `oup_ready_i=0` for 3 cycles after a grant → `oup_valid_o` and payload stable, no further grants; ready rises → handshake and new grant in same cycle.
- Assert `rst_i` with held entry and `inflight_o=3` → next cycle `oup_valid_o=0`, `inflight_o=0`, `idle_o=1`, `prio_q=0`.
- `en_i=0` with requesters valid and one held entry → held entry drains, no `inp_ready_o`; `en_i=1` → grants resume from `prio_q`.
